// File: rtl/cpu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_fsm
//
// Multi-cycle fetch/decode/execute controller for a small accumulator CPU.
// It sits directly upstream of the ALU. It fetches instruction bytes from ROM
// and holds the instruction register (ir) and the address register (ar). It
// drives every PC / ROM / RAM / accumulator control strobe for the datapath.
//
// Instruction timing, counted from FETCH to the next FETCH:
//   one-byte instructions      : FETCH LATCH DECODE EXEC WB                  (5)
//   two-byte instructions      : FETCH LATCH DECODE OPND_F OPND_L EXEC WB    (7)
//   JMP                        : FETCH LATCH DECODE OPND_F OPND_L            (5)
//   HLT                        : FETCH LATCH DECODE EXEC, then HALT until rst
//
// Ports:
//   clk       in   system clock, all state on the rising edge
//   rst       in   synchronous, active-high reset
//   instr     in   ROM read data, valid in the cycle after rom_rd
//   op        out  ALU opcode, the upper nibble of ir
//   imm       out  ALU immediate, the lower nibble of ir
//   ar        out  address register (RAM address; ROM address when addr_sel=1)
//   addr_sel  out  ROM address mux: 0 = PC, 1 = ar
//   rom_rd    out  ROM read strobe
//   ram_rd    out  RAM read strobe
//   ram_wr    out  RAM write strobe (write data is the accumulator)
//   pc_inc    out  PC += 1
//   pc_load   out  PC <= ar (the datapath muxes instr onto the PC load path)
//   acc_load  out  accumulator <= alu_out
//   dr_load   out  external data register <= RAM data
//   im_int    out  one-cycle ALU temp-register strobe
//   halted    out  high while in the HALT state
//   illegal   out  sticky flag, set when an undefined opcode is decoded
// -----------------------------------------------------------------------------
module cpu_ctrl_fsm #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    output logic [3:0]        op,
    output logic [3:0]        imm,
    output logic [DATA_W-1:0] ar,
    output logic              addr_sel,
    output logic              rom_rd,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic              pc_inc,
    output logic              pc_load,
    output logic              acc_load,
    output logic              dr_load,
    output logic              im_int,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_LATCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_OPND_F = 3'd3,
        ST_OPND_L = 3'd4,
        ST_EXEC   = 3'd5,
        ST_WB     = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDO = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STO = 4'h3;
    localparam logic [3:0] OP_PRE = 4'h4;
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_LDM = 4'h6;
    localparam logic [3:0] OP_ADN = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_CLR = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Instructions followed by an address byte.
    function automatic logic is_two_byte(input logic [3:0] opc);
        logic res;
        case (opc)
            OP_LDO, OP_LDA, OP_STO, OP_PRE,
            OP_ADD, OP_LDM, OP_JMP: res = 1'b1;
            default:                res = 1'b0;
        endcase
        return res;
    endfunction

    // Opcodes C, D and E have no meaning; they execute as NOP.
    function automatic logic is_undefined(input logic [3:0] opc);
        logic res;
        case (opc)
            4'hC, 4'hD, 4'hE: res = 1'b1;
            default:          res = 1'b0;
        endcase
        return res;
    endfunction

    // Instructions whose result lands in the accumulator during WB.
    function automatic logic writes_acc(input logic [3:0] opc);
        logic res;
        case (opc)
            OP_LDO, OP_LDA, OP_ADD, OP_ADN,
            OP_INC, OP_DEC, OP_CLR: res = 1'b1;
            default:                res = 1'b0;
        endcase
        return res;
    endfunction

    // Instructions whose RAM operand lands in the external data register.
    function automatic logic writes_dr(input logic [3:0] opc);
        logic res;
        case (opc)
            OP_PRE, OP_LDM: res = 1'b1;
            default:        res = 1'b0;
        endcase
        return res;
    endfunction

    state_t            state_q,   state_d;
    logic [DATA_W-1:0] ir_q,      ir_d;
    logic [DATA_W-1:0] ar_q,      ar_d;
    logic              illegal_q, illegal_d;

    logic [3:0] opc_s;

    logic addr_sel_s;
    logic rom_rd_s;
    logic ram_rd_s;
    logic ram_wr_s;
    logic pc_inc_s;
    logic pc_load_s;
    logic acc_load_s;
    logic dr_load_s;
    logic im_int_s;

    assign opc_s = ir_q[DATA_W-1 -: 4];

    // State, instruction, address and illegal-flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            ir_q      <= {DATA_W{1'b0}};
            ar_q      <= {DATA_W{1'b0}};
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ar_q      <= ar_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic and register updates.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        ar_d      = ar_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                ir_d    = instr;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_two_byte(opc_s)) begin
                    state_d = ST_OPND_F;
                end else begin
                    state_d = ST_EXEC;
                end
                if (is_undefined(opc_s)) begin
                    illegal_d = 1'b1;
                end else begin
                    illegal_d = illegal_q;
                end
            end
            ST_OPND_F: begin
                state_d = ST_OPND_L;
            end
            ST_OPND_L: begin
                // JMP finishes here: the PC takes the address byte directly,
                // so there is nothing left to execute.
                ar_d = instr;
                if (opc_s == OP_JMP) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (opc_s == OP_HLT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Moore decode of state plus ir into the datapath strobes.
    always_comb begin
        addr_sel_s = 1'b0;
        rom_rd_s   = 1'b0;
        ram_rd_s   = 1'b0;
        ram_wr_s   = 1'b0;
        pc_inc_s   = 1'b0;
        pc_load_s  = 1'b0;
        acc_load_s = 1'b0;
        dr_load_s  = 1'b0;
        im_int_s   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                rom_rd_s = 1'b1;
            end
            ST_LATCH: begin
                pc_inc_s = 1'b1;
            end
            ST_OPND_F: begin
                rom_rd_s = 1'b1;
            end
            ST_OPND_L: begin
                if (opc_s == OP_JMP) begin
                    pc_load_s = 1'b1;
                end else begin
                    pc_inc_s = 1'b1;
                end
            end
            ST_EXEC: begin
                case (opc_s)
                    OP_LDO: begin
                        rom_rd_s   = 1'b1;
                        addr_sel_s = 1'b1;
                    end
                    OP_LDA, OP_ADD, OP_PRE, OP_LDM: begin
                        ram_rd_s = 1'b1;
                    end
                    OP_STO: begin
                        ram_wr_s = 1'b1;
                    end
                    // CLR strobes the temp register with imm=0, clearing it.
                    OP_ADN, OP_CLR: begin
                        im_int_s = 1'b1;
                    end
                    default: begin
                        im_int_s = 1'b0;
                    end
                endcase
            end
            ST_WB: begin
                if (writes_acc(opc_s)) begin
                    acc_load_s = 1'b1;
                end else if (writes_dr(opc_s)) begin
                    dr_load_s = 1'b1;
                end else begin
                    acc_load_s = 1'b0;
                end
            end
            default: begin
                pc_inc_s = 1'b0;
            end
        endcase
    end

    // Strobes are suppressed while rst is high, so a mid-instruction reset
    // cannot leak a stray access from whatever state was current.
    assign addr_sel = addr_sel_s & ~rst;
    assign rom_rd   = rom_rd_s   & ~rst;
    assign ram_rd   = ram_rd_s   & ~rst;
    assign ram_wr   = ram_wr_s   & ~rst;
    assign pc_inc   = pc_inc_s   & ~rst;
    assign pc_load  = pc_load_s  & ~rst;
    assign acc_load = acc_load_s & ~rst;
    assign dr_load  = dr_load_s  & ~rst;
    assign im_int   = im_int_s   & ~rst;

    assign op      = opc_s;
    assign imm     = ir_q[3:0];
    assign ar      = ar_q;
    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: a cycle-by-cycle table of
// {rst, instr, expected strobes, ir, ar, illegal} records, applied through a
// scoreboard queue, followed by a hand-written HALT / reset sequence.
module tb_cpu_ctrl_fsm;

    localparam int DATA_W = 8;

    // Strobe vector bit order:
    // {addr_sel, rom_rd, ram_rd, ram_wr, pc_inc, pc_load, acc_load, dr_load, im_int, halted}
    localparam logic [9:0] M_NONE = 10'h000;
    localparam logic [9:0] M_ROMA = 10'h300;
    localparam logic [9:0] M_ROM  = 10'h100;
    localparam logic [9:0] M_RRD  = 10'h080;
    localparam logic [9:0] M_RWR  = 10'h040;
    localparam logic [9:0] M_INC  = 10'h020;
    localparam logic [9:0] M_PCL  = 10'h010;
    localparam logic [9:0] M_ACC  = 10'h008;
    localparam logic [9:0] M_DR   = 10'h004;
    localparam logic [9:0] M_IMI  = 10'h002;
    localparam logic [9:0] M_HLT  = 10'h001;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] instr;
    logic [3:0]        op;
    logic [3:0]        imm;
    logic [DATA_W-1:0] ar;
    logic addr_sel, rom_rd, ram_rd, ram_wr, pc_inc, pc_load;
    logic acc_load, dr_load, im_int, halted, illegal;

    always #5 clk = ~clk;

    cpu_ctrl_fsm #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .op       (op),
        .imm      (imm),
        .ar       (ar),
        .addr_sel (addr_sel),
        .rom_rd   (rom_rd),
        .ram_rd   (ram_rd),
        .ram_wr   (ram_wr),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .acc_load (acc_load),
        .dr_load  (dr_load),
        .im_int   (im_int),
        .halted   (halted),
        .illegal  (illegal)
    );

    typedef struct {
        logic       rst;
        logic [7:0] instr;
        logic [9:0] str;
        logic [7:0] ir;
        logic [7:0] ar;
        logic       ill;
        logic [9:0] mask;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Expected register contents while building the table.
    logic [7:0] e_ir;
    logic [7:0] e_ar;
    logic       e_ill;

    function automatic logic [9:0] strobes_now();
        return {addr_sel, rom_rd, ram_rd, ram_wr, pc_inc, pc_load,
                acc_load, dr_load, im_int, halted};
    endfunction

    task automatic add_row(input logic r, input logic [7:0] in_b, input logic [9:0] str);
        vec_t v;
        v.rst   = r;
        v.instr = in_b;
        v.str   = str;
        v.ir    = e_ir;
        v.ar    = e_ar;
        v.ill   = e_ill;
        v.mask  = 10'h3FF;
        vecs.push_back(v);
    endtask

    // One-byte instruction: FETCH LATCH DECODE EXEC WB (or HALT as last row).
    task automatic ins1(input logic [7:0] opc, input logic [9:0] ex,
                        input logic [9:0] wb, input logic undef);
        add_row(1'b0, 8'h00, M_ROM);
        add_row(1'b0, opc,   M_INC);
        e_ir = opc;
        add_row(1'b0, 8'h00, M_NONE);
        if (undef) e_ill = 1'b1;
        add_row(1'b0, 8'h00, ex);
        add_row(1'b0, 8'h00, wb);
    endtask

    // Two-byte instruction: FETCH LATCH DECODE OPND_F OPND_L EXEC WB.
    task automatic ins2(input logic [7:0] opc, input logic [7:0] addr,
                        input logic [9:0] ex, input logic [9:0] wb);
        add_row(1'b0, 8'h00, M_ROM);
        add_row(1'b0, opc,   M_INC);
        e_ir = opc;
        add_row(1'b0, 8'h00, M_NONE);
        add_row(1'b0, 8'h00, M_ROM);
        add_row(1'b0, addr,  M_INC);
        e_ar = addr;
        add_row(1'b0, 8'h00, ex);
        add_row(1'b0, 8'h00, wb);
    endtask

    // JMP: FETCH LATCH DECODE OPND_F OPND_L(pc_load), then straight to FETCH.
    task automatic jmp(input logic [7:0] addr);
        add_row(1'b0, 8'h00, M_ROM);
        add_row(1'b0, 8'hA0, M_INC);
        e_ir = 8'hA0;
        add_row(1'b0, 8'h00, M_NONE);
        add_row(1'b0, 8'h00, M_ROM);
        add_row(1'b0, addr,  M_PCL);
        e_ar = addr;
    endtask

    task automatic cmp(input string name, input int row, input logic [9:0] got, input logic [9:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s row %0d: got %03h expected %03h", name, row, got, want);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check at the falling edge.
    task automatic step(input vec_t v, input int row);
        vec_t e;
        @(posedge clk);
        #1;
        rst   = v.rst;
        instr = v.instr;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        cmp("strobes", row, strobes_now() & e.mask, e.str & e.mask);
        cmp("ir",      row, {2'b00, op, imm},       {2'b00, e.ir});
        cmp("ar",      row, {2'b00, ar},            {2'b00, e.ar});
        cmp("illegal", row, {9'd0, illegal},        {9'd0, e.ill});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst   = 1'b1;
        instr = 8'h00;
        e_ir  = 8'h00;
        e_ar  = 8'h00;
        e_ill = 1'b0;

        // Reset state: strobes forced low, registers cleared.
        add_row(1'b1, 8'h00, M_NONE);
        ins1(8'h80, M_NONE, M_ACC, 1'b0);          // INC
        ins2(8'h20, 8'h3C, M_RRD, M_ACC);          // LDA 0x3C
        jmp(8'h10);                                // JMP 0x10
        ins1(8'h73, M_IMI, M_ACC, 1'b0);           // ADN #3
        ins1(8'hB0, M_IMI, M_ACC, 1'b0);           // CLR
        ins2(8'h40, 8'h55, M_RRD, M_DR);           // PRE 0x55
        ins2(8'h30, 8'hFF, M_RWR, M_NONE);         // STO 0xFF
        ins2(8'h10, 8'h22, M_ROMA, M_ACC);         // LDO 0x22
        ins2(8'h50, 8'h01, M_RRD, M_ACC);          // ADD 0x01
        ins2(8'h60, 8'h02, M_RRD, M_DR);           // LDM 0x02
        ins1(8'h90, M_NONE, M_ACC, 1'b0);          // DEC
        ins1(8'h00, M_NONE, M_NONE, 1'b0);         // NOP
        ins1(8'hD5, M_NONE, M_NONE, 1'b1);         // undefined
        // LDO interrupted by reset during OPND_F.
        add_row(1'b0, 8'h00, M_ROM);
        add_row(1'b0, 8'h12, M_INC);
        e_ir = 8'h12;
        add_row(1'b0, 8'h00, M_NONE);
        add_row(1'b1, 8'h00, M_NONE);
        e_ir  = 8'h00;
        e_ar  = 8'h00;
        e_ill = 1'b0;
        ins1(8'hF0, M_NONE, M_HLT, 1'b0);          // HLT

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // HALT holds with no strobes for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            v = '{1'b0, 8'h00, M_HLT, 8'hF0, 8'h00, 1'b0, 10'h3FF};
            step(v, 1000 + i);
        end
        // Reset cycle out of HALT: every strobe low.
        v = '{1'b1, 8'h00, M_NONE, 8'hF0, 8'h00, 1'b0, 10'h3FE};
        step(v, 2000);
        // First cycle after reset: FETCH with rom_rd, halted cleared.
        v = '{1'b0, 8'h00, M_ROM, 8'h00, 8'h00, 1'b0, 10'h3FF};
        step(v, 2001);
        v = '{1'b0, 8'h80, M_INC, 8'h00, 8'h00, 1'b0, 10'h3FF};
        step(v, 2002);
        v = '{1'b0, 8'h00, M_NONE, 8'h80, 8'h00, 1'b0, 10'h3FF};
        step(v, 2003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle fetch/decode/execute controller sitting directly upstream of the ALU.
- Fetches instruction bytes from ROM and holds the instruction and address registers.
- Drives the ALU opcode, immediate and im_int strobe, plus all PC/ROM/RAM/accumulator control strobes for the datapath.
- One instruction completes every 5 or 7 clocks; the accumulator is written from alu_out on acc_load.

Parameters:
DATA_W, 8, width of instruction/operand bytes and of the address register (opcode is fixed at 4 bits).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
instr  in  DATA_W  ROM read data (valid in the cycle after rom_rd)
op  out  4  ALU opcode = ir[7:4]
imm  out  4  ALU immediate = ir[3:0]
ar  out  DATA_W  address register (RAM address; ROM address when addr_sel=1)
addr_sel  out  1  ROM address mux: 0=PC, 1=ar
rom_rd  out  1  ROM read strobe
ram_rd  out  1  RAM read strobe
ram_wr  out  1  RAM write strobe (data = accumulator)
pc_inc  out  1  PC += 1
pc_load  out  1  PC <= ar
acc_load  out  1  accumulator <= alu_out
dr_load  out  1  external data register <= RAM data
im_int  out  1  one-cycle ALU temp-register strobe
halted  out  1  high in HALT state
illegal  out  1  sticky undefined-opcode flag

Behaviour:
- Opcodes: NOP 0, LDO 1, LDA 2, STO 3, PRE 4, ADD 5, LDM 6, ADN 7, INC 8, DEC 9, JMP A, CLR B, HLT F. Opcodes C/D/E are undefined.
- Two-byte instructions (opcode byte, then address byte): LDO, LDA, STO, PRE, ADD, LDM, JMP. All others are one byte.
- States: FETCH, LATCH, DECODE, OPND_F, OPND_L, EXEC, WB, HALT.
- Strobes are a Moore decode of state plus ir. Unlisted strobes are 0.
- FETCH: rom_rd=1, addr_sel=0 -> LATCH.
- LATCH: ir<=instr, pc_inc=1 -> DECODE.
- DECODE: two-byte -> OPND_F; else -> EXEC. Undefined opcode sets illegal=1 and executes as NOP.
- OPND_F: rom_rd=1, addr_sel=0 -> OPND_L.
- OPND_L: ar<=instr, pc_inc=1 -> EXEC. For JMP only: ar<=instr, pc_load=1, no pc_inc -> FETCH.
  - PC is loaded with the new ar value. The datapath resolves this by muxing instr onto the PC load path in this state; the controller asserts pc_load in OPND_L.
- EXEC, per opcode:
  - LDO: rom_rd=1, addr_sel=1.
  - LDA, ADD, PRE, LDM: ram_rd=1.
  - STO: ram_wr=1.
  - ADN, CLR: im_int=1. CLR therefore zeroes the ALU temp register.
  - HLT: -> HALT. Otherwise -> WB.
- WB:
  - acc_load=1 for LDO, LDA, ADD, ADN, INC, DEC, CLR.
  - dr_load=1 for PRE, LDM.
  - No strobe for STO, NOP or undefined opcodes.
  - -> FETCH.
- HALT: halted=1, all strobes 0. Remains in HALT until rst.
- Latency: one-byte instructions take 5 clocks, FETCH to next FETCH. Two-byte non-JMP take 7 clocks. JMP takes 5 clocks.
- im_int is exactly one cycle wide and is never asserted outside EXEC.
- ram_rd/ram_wr/rom_rd are never asserted simultaneously.
- Reset (any state, including mid-instruction):
  - Next state is FETCH; ir=0 (op=NOP, imm=0), ar=0.
  - illegal=0, halted=0.
  - While rst=1 all strobes are forced to 0. The first rom_rd occurs in the first cycle after rst deasserts.
- ar wraps naturally within DATA_W. No overflow handling is done here; arithmetic width is the ALU's concern.

Test Plan:
1. Reset then ROM[0]=0x80 (INC) -> rom_rd in cycle 0, pc_inc in cycle 1, op=8 from cycle 2, acc_load only in cycle 4, rom_rd again in cycle 5.
2. ROM 0x20,0x3C (LDA 0x3C) -> ar=0x3C after cycle 4, ram_rd in cycle 5, acc_load in cycle 6, two pc_inc pulses total, next fetch in cycle 7.
3. ROM 0xA0,0x10 (JMP 0x10) -> pc_load=1 with ar<=0x10 in cycle 4, one pc_inc, no acc_load, FETCH in cycle 5.
4. ADN imm=3 (0x73) then CLR (0xB0) -> single-cycle im_int in EXEC of each instruction with op=7 then op=B, acc_load in each WB.
5. 0xF0 (HLT) -> halted=1 from cycle 4, no strobes for 20 cycles; rst pulse -> halted=0, FETCH resumes.
6. 0xD5 (undefined), then rst asserted during OPND_F of a following LDO -> illegal=1 after DECODE with no acc_load; after rst illegal=0, ar=0, op=0, rom_rd first in the cycle after rst falls.
